seq_ctrl: RTL and testbench
===========================

SEQ_CTRL -- requirements
Module: seq_ctrl

Interface
REQ-001 Parameter COLOR_WIDTH, default 2: width of one colour symbol; must equal the LFSR rnd width.
REQ-002 Parameter MAX_LEN, default 16: sequence length that wins the game; minimum 2.
REQ-003 Parameter SHOW_CYCLES, default 4: cycles each colour is displayed; minimum 1.
REQ-004 Parameter GAP_CYCLES, default 2: blank cycles after each displayed colour; minimum 1.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 start  input  1  start or restart request, sampled per cycle.
REQ-008 rnd  input  COLOR_WIDTH  random colour from the upstream LFSR, free-running.
REQ-009 btn_valid  input  1  one-cycle player press strobe.
REQ-010 btn_color  input  COLOR_WIDTH  colour pressed; qualified by btn_valid.
REQ-011 led_valid  output  1  a colour is being displayed.
REQ-012 led_color  output  COLOR_WIDTH  displayed colour; 0 when led_valid=0.
REQ-013 level  output  $clog2(MAX_LEN+1)  current sequence length.
REQ-014 busy  output  1  game in progress (ADD, SHOW_ON, SHOW_OFF or WAIT_IN).
REQ-015 in_turn  output  1  high in WAIT_IN; player input accepted.
REQ-016 win  output  1  high in WIN.
REQ-017 lose  output  1  high in LOSE.

Function
REQ-018 FSM states: IDLE, ADD, SHOW_ON, SHOW_OFF, WAIT_IN, WIN, LOSE; all outputs decoded from registered state, counters and memory.
REQ-019 IDLE/WIN/LOSE with start=1: clear length to 0 and index to 0, go to ADD next cycle; start is ignored in all other states.
REQ-020 ADD (one cycle): write rnd to mem[length], increment length, clear index, go to SHOW_ON.
REQ-021 SHOW_ON: led_valid=1, led_color=mem[index] for exactly SHOW_CYCLES cycles, then SHOW_OFF.
REQ-022 SHOW_OFF: led_valid=0 for exactly GAP_CYCLES cycles; then, if index=length-1, clear index and go to WAIT_IN; otherwise increment index and go to SHOW_ON.
REQ-023 WAIT_IN with btn_valid=1 and btn_color=mem[index]: if index<length-1, increment index; otherwise go to WIN if length=MAX_LEN, else go to ADD.
REQ-024 WAIT_IN with btn_valid=1 and btn_color!=mem[index]: go to LOSE; length is held for readout.
REQ-025 btn_valid is ignored outside WAIT_IN; presses during display are discarded and not queued.
REQ-026 WIN and LOSE are sticky until start or rst.
REQ-027 Latency: start accepted at edge N gives ADD in cycle N+1 and the first led_valid=1 in cycle N+2.
REQ-028 level equals length; it increments in the cycle after ADD and never exceeds MAX_LEN.
REQ-029 Memory entries at index >= length are never read or compared.

Reset
REQ-030 rst=1 at a clock edge forces IDLE, length=0, index=0 and cycle counter=0 in any state, including mid-display and mid-input.
REQ-031 After reset: led_valid, led_color, level, busy, in_turn, win and lose are all 0; memory contents are don't-care.
REQ-032 rst has priority over start and btn_valid in the same cycle.

Structure
REQ-033 Package seq_pkg holds the state enum type, the colour typedef (logic [COLOR_WIDTH-1:0]) and the named colour constants (RED=0, GREEN=1, BLUE=2, YELLOW=3).
REQ-034 Sub-module seq_mem holds the storage: MAX_LEN x COLOR_WIDTH register file, one synchronous write port and one combinational read port, with no reset on its contents.
REQ-035 A single down-counter sized for max(SHOW_CYCLES, GAP_CYCLES) provides the timing for both SHOW_ON and SHOW_OFF.

Verification (MAX_LEN=4, SHOW_CYCLES=3, GAP_CYCLES=2)
REQ-036 Reset then start with rnd=2 -> ADD in the next cycle, level=1, led_valid high for 3 cycles with led_color=2, 2 blank cycles, then in_turn=1.
REQ-037 Rounds adding rnd=1,3,0,2 with every press correct -> each round replays the full prefix; after the 4th correct press win=1, level=4, busy=0.
REQ-038 Level 3 stored 1,3,0; press 1, then 2 -> lose=1 on the next cycle, level stays 3; further btn_valid pulses are ignored.
REQ-039 btn_valid pulses during SHOW_ON/SHOW_OFF -> no state change; the first press in WAIT_IN is compared against mem[0].
REQ-040 rst asserted in the 2nd cycle of SHOW_ON -> the next cycle is IDLE with all outputs 0; start in WAIT_IN is ignored.
REQ-041 From LOSE, start with rnd=3 -> level=1 and a new sequence with led_color=3 is shown.

Source files
------------

// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared types and constants for the colour-sequence game controller
package seq_pkg;

  localparam int COLOR_WIDTH = 2;

  typedef logic [COLOR_WIDTH-1:0] color_t;

  localparam color_t RED    = 2'd0;
  localparam color_t GREEN  = 2'd1;
  localparam color_t BLUE   = 2'd2;
  localparam color_t YELLOW = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADD,
    S_SHOW_ON,
    S_SHOW_OFF,
    S_WAIT_IN,
    S_WIN,
    S_LOSE
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seq_mem.sv
// rtl/seq_mem.sv - sequence register file, one synchronous write port, one combinational read port
module seq_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  // Contents are intentionally unreset; entries are always written before being read.
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/seq_ctrl.sv
// rtl/seq_ctrl.sv - colour-sequence memory game controller: grows, replays and checks a sequence
module seq_ctrl
  import seq_pkg::*;
#(
  parameter int COLOR_WIDTH = 2,
  parameter int MAX_LEN     = 16,
  parameter int SHOW_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int LW          = $clog2(MAX_LEN + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [COLOR_WIDTH-1:0] rnd,
  input  logic                   btn_valid,
  input  logic [COLOR_WIDTH-1:0] btn_color,
  output logic                   led_valid,
  output logic [COLOR_WIDTH-1:0] led_color,
  output logic [LW-1:0]          level,
  output logic                   busy,
  output logic                   in_turn,
  output logic                   win,
  output logic                   lose
);

  localparam int IW      = $clog2(MAX_LEN);
  localparam int CNT_MAX = max_int(SHOW_CYCLES, GAP_CYCLES);
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] SHOW_LOAD = CW'(SHOW_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
  localparam logic [LW-1:0] LEN_WIN   = LW'(MAX_LEN);

  state_t                 state_q, state_d;
  logic [LW-1:0]          length_q, length_d;
  logic [IW-1:0]          index_q, index_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   mem_we;
  logic [COLOR_WIDTH-1:0] rd_data;
  logic                   at_last;

  seq_mem #(
    .DEPTH (MAX_LEN),
    .WIDTH (COLOR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (length_q[IW-1:0]),
    .wdata_i (rnd),
    .raddr_i (index_q),
    .rdata_o (rd_data)
  );

  assign at_last = (LW'(index_q) == (length_q - LW'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      length_q <= '0;
      index_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      length_q <= length_d;
      index_q  <= index_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    length_d = length_q;
    index_d  = index_q;
    cnt_d    = cnt_q;
    mem_we   = 1'b0;
    unique case (state_q)
      S_IDLE, S_WIN, S_LOSE: begin
        if (start) begin
          length_d = '0;
          index_d  = '0;
          state_d  = S_ADD;
        end
      end
      S_ADD: begin
        mem_we   = 1'b1;
        length_d = length_q + LW'(1);
        index_d  = '0;
        cnt_d    = SHOW_LOAD;
        state_d  = S_SHOW_ON;
      end
      S_SHOW_ON: begin
        if (cnt_q == '0) begin
          cnt_d   = GAP_LOAD;
          state_d = S_SHOW_OFF;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_SHOW_OFF: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (at_last) begin
          index_d = '0;
          state_d = S_WAIT_IN;
        end else begin
          index_d = index_q + IW'(1);
          cnt_d   = SHOW_LOAD;
          state_d = S_SHOW_ON;
        end
      end
      S_WAIT_IN: begin
        if (btn_valid) begin
          if (btn_color != rd_data) begin
            state_d = S_LOSE;
          end else if (!at_last) begin
            index_d = index_q + IW'(1);
          end else if (length_q == LEN_WIN) begin
            state_d = S_WIN;
          end else begin
            state_d = S_ADD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign led_valid = (state_q == S_SHOW_ON);
  assign led_color = led_valid ? rd_data : '0;
  assign level     = length_q;
  assign busy      = (state_q == S_ADD) || (state_q == S_SHOW_ON) ||
                     (state_q == S_SHOW_OFF) || (state_q == S_WAIT_IN);
  assign in_turn   = (state_q == S_WAIT_IN);
  assign win       = (state_q == S_WIN);
  assign lose      = (state_q == S_LOSE);

endmodule

// File: tb/tb_seq_ctrl.sv
// tb/tb_seq_ctrl.sv - directed self-checking bench for seq_ctrl (MAX_LEN=4, SHOW=3, GAP=2)
module tb_seq_ctrl;
  import seq_pkg::*;

  localparam int ML = 4;
  localparam int SC = 3;
  localparam int GC = 2;
  localparam int LW = $clog2(ML + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    rnd = 2'd0;
  logic          btn_valid = 1'b0;
  logic [1:0]    btn_color = 2'd0;
  logic          led_valid;
  logic [1:0]    led_color;
  logic [LW-1:0] level;
  logic          busy, in_turn, win, lose;

  int vectors = 0;
  int miscompares = 0;
  logic [1:0] seq_m [ML];
  int len_m = 0;

  seq_ctrl #(
    .COLOR_WIDTH (2),
    .MAX_LEN     (ML),
    .SHOW_CYCLES (SC),
    .GAP_CYCLES  (GC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rnd       (rnd),
    .btn_valid (btn_valid),
    .btn_color (btn_color),
    .led_valid (led_valid),
    .led_color (led_color),
    .level     (level),
    .busy      (busy),
    .in_turn   (in_turn),
    .win       (win),
    .lose      (lose)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack(input logic lv, input logic [1:0] col, input int lvl,
                                       input logic b, input logic t, input logic w, input logic l);
    logic [LW-1:0] lvl_w;
    lvl_w = LW'(lvl);
    return {22'd0, lv, col, lvl_w, b, t, w, l};
  endfunction

  function automatic logic [31:0] obs_vec();
    return {22'd0, led_valid, led_color, level, busy, in_turn, win, lose};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // From an ADD cycle: supply rnd, then check the whole replay ending in WAIT_IN.
  task automatic add_and_show(input string tag, input logic [1:0] r, input logic noisy);
    rnd = r;
    step();
    seq_m[len_m] = r;
    len_m++;
    for (int i = 0; i < len_m; i++) begin
      for (int c = 0; c < SC; c++) begin
        chk({tag, "_on"}, obs_vec(), pack(1'b1, seq_m[i], len_m, 1'b1, 1'b0, 1'b0, 1'b0));
        if (noisy) begin
          btn_valid = 1'b1;
          btn_color = seq_m[i] + 2'd1;
        end
        step();
        btn_valid = 1'b0;
      end
      for (int c = 0; c < GC; c++) begin
        chk({tag, "_gap"}, obs_vec(), pack(1'b0, 2'd0, len_m, 1'b1, 1'b0, 1'b0, 1'b0));
        if (noisy) begin
          btn_valid = 1'b1;
          btn_color = seq_m[0] + 2'd1;
        end
        step();
        btn_valid = 1'b0;
      end
    end
    chk({tag, "_wait"}, obs_vec(), pack(1'b0, 2'd0, len_m, 1'b1, 1'b1, 1'b0, 1'b0));
  endtask

  task automatic press(input logic [1:0] col);
    btn_valid = 1'b1;
    btn_color = col;
    step();
    btn_valid = 1'b0;
  endtask

  task automatic do_start(input string tag, input logic [1:0] r);
    start = 1'b1;
    rnd = r;
    step();
    start = 1'b0;
    len_m = 0;
    chk({tag, "_add"}, obs_vec(), pack(1'b0, 2'd0, 0, 1'b1, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic press_round(input string tag);
    for (int i = 0; i < len_m; i++) begin
      press(seq_m[i]);
      if (i < len_m - 1)
        chk({tag, "_mid"}, obs_vec(), pack(1'b0, 2'd0, len_m, 1'b1, 1'b1, 1'b0, 1'b0));
      else if (len_m == ML)
        chk({tag, "_win"}, obs_vec(), pack(1'b0, 2'd0, len_m, 1'b0, 1'b0, 1'b1, 1'b0));
      else
        chk({tag, "_add"}, obs_vec(), pack(1'b0, 2'd0, len_m, 1'b1, 1'b0, 1'b0, 1'b0));
    end
  endtask

  initial begin
    do_reset();
    chk("reset", obs_vec(), pack(1'b0, 2'd0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
    step();
    chk("idle_hold", obs_vec(), pack(1'b0, 2'd0, 0, 1'b0, 1'b0, 1'b0, 1'b0));

    do_start("first", BLUE);
    add_and_show("first", BLUE, 1'b0);

    do_reset();
    chk("reset_wait", obs_vec(), pack(1'b0, 2'd0, 0, 1'b0, 1'b0, 1'b0, 1'b0));

    // Full game to a win; round 2 is peppered with ignored presses.
    do_start("game", GREEN);
    add_and_show("r1", GREEN, 1'b0);
    press_round("r1p");
    add_and_show("r2", YELLOW, 1'b1);
    press(seq_m[0]);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_in_wait", obs_vec(), pack(1'b0, 2'd0, 2, 1'b1, 1'b1, 1'b0, 1'b0));
    press(seq_m[1]);
    chk("r2_done", obs_vec(), pack(1'b0, 2'd0, 2, 1'b1, 1'b0, 1'b0, 1'b0));
    add_and_show("r3", RED, 1'b0);
    press_round("r3p");
    add_and_show("r4", BLUE, 1'b0);
    press_round("r4p");
    for (int k = 0; k < 3; k++) begin
      btn_valid = 1'b1;
      btn_color = RED;
      step();
      btn_valid = 1'b0;
      chk("win_sticky", obs_vec(), pack(1'b0, 2'd0, 4, 1'b0, 1'b0, 1'b1, 1'b0));
    end

    // Reset in the second SHOW_ON cycle, with start and a press held alongside.
    do_start("midrst", BLUE);
    rnd = BLUE;
    step();
    step();
    chk("midrst_on2", obs_vec(), pack(1'b1, BLUE, 1, 1'b1, 1'b0, 1'b0, 1'b0));
    rst = 1'b1;
    start = 1'b1;
    btn_valid = 1'b1;
    step();
    rst = 1'b0;
    start = 1'b0;
    btn_valid = 1'b0;
    chk("midrst_idle", obs_vec(), pack(1'b0, 2'd0, 0, 1'b0, 1'b0, 1'b0, 1'b0));

    // Build 1,3,0 then miss on the second press.
    do_start("lose", GREEN);
    add_and_show("l1", GREEN, 1'b0);
    press_round("l1p");
    add_and_show("l2", YELLOW, 1'b0);
    press_round("l2p");
    add_and_show("l3", RED, 1'b0);
    press(GREEN);
    chk("l3_first", obs_vec(), pack(1'b0, 2'd0, 3, 1'b1, 1'b1, 1'b0, 1'b0));
    press(BLUE);
    chk("l3_lose", obs_vec(), pack(1'b0, 2'd0, 3, 1'b0, 1'b0, 1'b0, 1'b1));
    press(GREEN);
    chk("lose_sticky", obs_vec(), pack(1'b0, 2'd0, 3, 1'b0, 1'b0, 1'b0, 1'b1));

    do_start("restart", YELLOW);
    add_and_show("restart", YELLOW, 1'b0);
    press(RED);
    chk("restart_lose", obs_vec(), pack(1'b0, 2'd0, 1, 1'b0, 1'b0, 1'b0, 1'b1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
